// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock quality monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

  localparam int DEF_CW = 16;

  // True when |meas - exp_v| <= tol; the extra bit keeps the subtraction from wrapping.
  function automatic logic abs_diff_le(input logic [31:0] meas,
                                       input logic [31:0] exp_v,
                                       input logic [31:0] tol);
    logic [32:0] diff;
    diff = (meas >= exp_v) ? ({1'b0, meas} - {1'b0, exp_v})
                           : ({1'b0, exp_v} - {1'b0, meas});
    return diff <= {1'b0, tol};
  endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// Brings the divided clock into the clk domain and flags its sampled rising edge.
module clk_edge_sync #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  output logic s,
  output logic rise
);

  logic s_q;
  logic s_d;

  generate
    if (SYNC_EN) begin : g_sync2
      logic meta;
      // NOTE: non-blocking (<=) on every flop so each stage sees its pre-edge input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta <= 1'b0;
          s_q  <= 1'b0;
        end else begin
          meta <= clk_in;
          s_q  <= meta;
        end
      end
    end else begin : g_sync1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= 1'b0;
        else        s_q <= clk_in;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s_q;
  end

  assign s    = s_q;
  assign rise = s_q & ~s_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock, tracks lock, period errors and clock loss.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter bit          SYNC_EN    = 1'b1,
  parameter int unsigned EXP_PERIOD = 5,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int          CW         = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_in,
  input  logic          clr,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_cnt,
  output logic          meas_valid,
  output logic          locked,
  output logic          err,
  output logic          timeout_flag
);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [8:0]    LOCK_THR = 9'(LOCK_CNT);

  logic          s;
  logic          rise;
  logic [CW-1:0] per_cnt;
  logic [CW-1:0] hi_cnt;
  logic [7:0]    good_cnt;
  logic [7:0]    good_nxt;
  logic [8:0]    good_inc;
  logic          meas_good;
  logic          timeout_hit;
  logic          meas_fire;
  logic          locked_nxt;
  logic          err_nxt;
  logic          tflag_nxt;
  mon_state_e    state;
  mon_state_e    state_nxt;

  clk_edge_sync #(.SYNC_EN(SYNC_EN)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_in (clk_in),
    .s      (s),
    .rise   (rise)
  );

  assign meas_good   = abs_diff_le(32'(per_cnt), 32'(EXP_PERIOD), 32'(TOL));
  // Fires on the cycle per_cnt is about to become TIMEOUT, so the flag and count appear together.
  assign timeout_hit = !rise && (per_cnt == TO_LAST);
  assign good_inc    = {1'b0, good_cnt} + 9'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEEK;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    good_nxt   = good_cnt;
    locked_nxt = locked;
    err_nxt    = err;
    tflag_nxt  = timeout_flag;
    meas_fire  = 1'b0;
    if (clr) err_nxt = 1'b0;
    if (rise) begin
      tflag_nxt = 1'b0;
      case (state)
        SEEK: begin
          state_nxt = TRACK;
          good_nxt  = '0;
        end
        TRACK: begin
          meas_fire = 1'b1;
          if (!meas_good) begin
            good_nxt = '0;
          end else begin
            good_nxt = good_inc[7:0];
            if (good_inc >= LOCK_THR) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end
          end
        end
        LOCKED: begin
          meas_fire = 1'b1;
          if (!meas_good) begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            good_nxt   = '0;
            state_nxt  = TRACK;
          end
        end
        default: state_nxt = SEEK;
      endcase
    end else if (timeout_hit) begin
      tflag_nxt  = 1'b1;
      locked_nxt = 1'b0;
      good_nxt   = '0;
      state_nxt  = SEEK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt      <= '0;
      hi_cnt       <= '0;
      good_cnt     <= '0;
      period       <= '0;
      high_cnt     <= '0;
      meas_valid   <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (rise)                   per_cnt <= CW'(1);
      else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CW'(1);
      if (rise)                         hi_cnt <= CW'(1);
      else if (s && hi_cnt != CNT_MAX)  hi_cnt <= hi_cnt + CW'(1);
      good_cnt     <= good_nxt;
      locked       <= locked_nxt;
      err          <= err_nxt;
      timeout_flag <= tflag_nxt;
      meas_valid   <= meas_fire;
      if (meas_fire) begin
        period   <= per_cnt;
        high_cnt <= hi_cnt;
      end
    end
  end

endmodule
